seg_scan_controller: RTL and testbench

- Sequences a 4-digit common-anode seven-segment display using the divided clocks from the board clock divider.
- The 500Hz output drives the digit scan; the 5Hz output drives digit blinking.
- Inserts an anti-ghosting blank interval between digits, decodes hex digits, and applies leading-zero suppression.
- Sits between the display-value logic of the lab designs and the board's anode and segment pins.

---
 rtl/seg_scan_controller.sv | 162 ++++++++++++++++
 tb/tb_seg_scan_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_controller.sv
// Four-digit common-anode seven-segment scanner: one digit per scan tick, an
// all-off blank gap between digits, hex decode, blinking and leading-zero blanking.
module seg_scan_controller #(
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        scan_tick,
  input  logic        blink_clk,
  input  logic [15:0] digits,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp_mask,
  input  logic        lz_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  cur_digit
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] DRIVE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(BLANK_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cur_q, cur_d;
  logic             scan_q;
  logic [6:0]       seg_lat_q, seg_lat_d;
  logic             dp_lat_q, dp_lat_d;
  logic             sup_q, sup_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic       tick;
  logic [3:0] nibble;
  logic       sup_now;
  logic [6:0] seg_now;
  logic       lit;

  assign tick   = scan_tick & ~scan_q;
  assign nibble = digits[{cur_q, 2'b00} +: 4];

  always_comb begin
    sup_now = 1'b0;
    case (cur_q)
      2'd1:    sup_now = lz_en && (digits[15:4] == 12'h000);
      2'd2:    sup_now = lz_en && (digits[15:8] == 8'h00);
      2'd3:    sup_now = lz_en && (digits[15:12] == 4'h0);
      default: sup_now = 1'b0;
    endcase
  end

  always_comb begin
    seg_now = 7'h7F;
    case (nibble)
      4'h0: seg_now = 7'h40;
      4'h1: seg_now = 7'h79;
      4'h2: seg_now = 7'h24;
      4'h3: seg_now = 7'h30;
      4'h4: seg_now = 7'h19;
      4'h5: seg_now = 7'h12;
      4'h6: seg_now = 7'h02;
      4'h7: seg_now = 7'h78;
      4'h8: seg_now = 7'h00;
      4'h9: seg_now = 7'h10;
      4'hA: seg_now = 7'h08;
      4'hB: seg_now = 7'h03;
      4'hC: seg_now = 7'h46;
      4'hD: seg_now = 7'h21;
      4'hE: seg_now = 7'h06;
      4'hF: seg_now = 7'h0E;
      default: seg_now = 7'h7F;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    seg_lat_d = seg_lat_q;
    dp_lat_d  = dp_lat_q;
    sup_d     = sup_q;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = BLANK;
          cnt_d   = '0;
        end
      end
      BLANK: begin
        if (cnt_q == CNT_TC) begin
          state_d   = DRIVE;
          seg_lat_d = seg_now;
          dp_lat_d  = dp_mask[cur_q];
          sup_d     = sup_now;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRIVE: begin
        if (tick) begin
          state_d = BLANK;
          cnt_d   = '0;
          cur_d   = cur_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      cur_d   = cur_q;
    end
  end

  // The output flops act as the blink_q stage, so blink edges reach the pins one cycle later.
  always_comb begin
    lit  = (state_d == DRIVE) && !sup_d && !(blink_mask[cur_d] && blink_clk);
    an_d  = lit ? ~(4'b0001 << cur_d) : 4'b1111;
    seg_d = lit ? seg_lat_d : 7'h7F;
    dp_d  = lit ? ~dp_lat_d : 1'b1;
  end

  always_ff @(posedge clk) begin
    scan_q <= scan_tick;
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cur_q     <= 2'd0;
      seg_lat_q <= 7'h7F;
      dp_lat_q  <= 1'b0;
      sup_q     <= 1'b0;
      an_q      <= 4'b1111;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      seg_lat_q <= seg_lat_d;
      dp_lat_q  <= dp_lat_d;
      sup_q     <= sup_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign cur_digit = cur_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: table-driven digit sequences, hand-written corner
// sequences, then randomized traffic against a cycle-level behavioural model.
module tb_seg_scan_controller;

  localparam int B = 4;

  logic        clk = 1'b0;
  logic        rst, en, scan_tick, blink_clk, lz_en;
  logic [15:0] digits;
  logic [3:0]  blink_mask, dp_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  cur_digit;

  int n_tests = 0;
  int n_fail  = 0;

  seg_scan_controller #(.BLANK_CYCLES(B), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .scan_tick(scan_tick), .blink_clk(blink_clk),
    .digits(digits), .blink_mask(blink_mask), .dp_mask(dp_mask), .lz_en(lz_en),
    .an(an), .seg(seg), .dp(dp), .cur_digit(cur_digit)
  );

  always #5 clk = ~clk;

  logic [6:0] hex7 [16];

  // Model: mode 0 = dark/waiting, 1 = gap with 'left' cycles to go, 2 = showing a digit.
  int   m_mode, m_left, m_cur, m_val;
  bit   m_dpb, m_sup, m_prev, m_blink;
  logic [3:0] m_bm;

  task automatic model_update();
    bit t;
    if (rst) begin
      m_mode = 0; m_left = 0; m_cur = 0;
      m_prev = scan_tick; m_blink = blink_clk; m_bm = blink_mask;
    end else begin
      t = scan_tick && !m_prev;
      m_prev = scan_tick; m_blink = blink_clk; m_bm = blink_mask;
      if (!en) m_mode = 0;
      else if (m_mode == 0) begin
        if (t) begin m_mode = 1; m_left = B; end
      end else if (m_mode == 1) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_mode = 2;
          m_val  = int'((digits >> (4 * m_cur)) & 16'hF);
          m_sup  = lz_en && (m_cur != 0) && ((digits >> (4 * m_cur)) == 16'h0);
          m_dpb  = dp_mask[m_cur];
        end
      end else if (t) begin
        m_cur  = (m_cur + 1) % 4;
        m_mode = 1; m_left = B;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_check();
    bit l;
    logic [3:0] e_an;
    l = (m_mode == 2) && !m_sup && !(m_bm[m_cur] && m_blink);
    e_an = l ? ~(4'b0001 << m_cur) : 4'b1111;
    check("model_an", {28'h0, an}, {28'h0, e_an});
    check("model_seg", {25'h0, seg}, l ? {25'h0, hex7[m_val]} : 32'h7F);
    check("model_dp", {31'h0, dp}, l ? {31'h0, !m_dpb} : 32'h1);
    check("model_cur", {30'h0, cur_digit}, m_cur);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    model_check();
  endtask

  task automatic do_reset();
    rst = 1'b1; scan_tick = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic tick_and_wait();
    scan_tick = 1'b1; step();
    scan_tick = 1'b0;
    repeat (B) step();
  endtask

  typedef struct {
    logic [15:0]     digits;
    logic [3:0]      dpm;
    logic            lz;
    logic [3:0][6:0] seg;
    logic [3:0]      lit;
  } vec_t;

  vec_t tbl [5];
  int   half;
  int   hcnt;

  initial begin
    hex7[0] = 7'h40; hex7[1] = 7'h79; hex7[2] = 7'h24; hex7[3] = 7'h30;
    hex7[4] = 7'h19; hex7[5] = 7'h12; hex7[6] = 7'h02; hex7[7] = 7'h78;
    hex7[8] = 7'h00; hex7[9] = 7'h10; hex7[10] = 7'h08; hex7[11] = 7'h03;
    hex7[12] = 7'h46; hex7[13] = 7'h21; hex7[14] = 7'h06; hex7[15] = 7'h0E;

    tbl[0] = '{16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
    tbl[1] = '{16'h0050, 4'b1111, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b0011};
    tbl[2] = '{16'h0050, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1111};
    tbl[3] = '{16'h8AF0, 4'b0100, 1'b1, {7'h00, 7'h08, 7'h0E, 7'h40}, 4'b1111};
    tbl[4] = '{16'h0000, 4'b0001, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0001};

    rst = 1'b1; en = 1'b1; scan_tick = 1'b0; blink_clk = 1'b0;
    digits = 16'h0; blink_mask = 4'h0; dp_mask = 4'h0; lz_en = 1'b0;

    do_reset();
    check("reset_an", {28'h0, an}, 32'hF);
    check("reset_seg", {25'h0, seg}, 32'h7F);
    check("reset_dp", {31'h0, dp}, 32'h1);

    for (int r = 0; r < 5; r++) begin
      digits = tbl[r].digits; dp_mask = tbl[r].dpm; lz_en = tbl[r].lz;
      blink_mask = 4'h0; en = 1'b1; blink_clk = 1'b0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
        scan_tick = 1'b1; step();
        check("tbl_blank_first", {28'h0, an}, 32'hF);
        scan_tick = 1'b0;
        repeat (B - 1) step();
        check("tbl_blank_last", {28'h0, an}, 32'hF);
        step();
        check("tbl_an", {28'h0, an}, tbl[r].lit[i] ? {28'h0, ~(4'b0001 << i)} : 32'hF);
        check("tbl_seg", {25'h0, seg}, {25'h0, tbl[r].seg[i]});
        check("tbl_dp", {31'h0, dp}, tbl[r].lit[i] ? {31'h0, ~tbl[r].dpm[i]} : 32'h1);
        check("tbl_cur", {30'h0, cur_digit}, i);
      end
    end

    // Reset released with scan_tick already high: no advance until a fresh edge.
    digits = 16'h1234; lz_en = 1'b0; dp_mask = 4'h0;
    rst = 1'b1; scan_tick = 1'b1; step(); step();
    rst = 1'b0;
    repeat (6) step();
    check("hi_rel_an", {28'h0, an}, 32'hF);
    check("hi_rel_cur", {30'h0, cur_digit}, 0);
    scan_tick = 1'b0; step();
    tick_and_wait();
    check("hi_rel_first_an", {28'h0, an}, 32'hE);
    check("hi_rel_first_cur", {30'h0, cur_digit}, 0);

    // Tick two cycles into the gap is dropped.
    scan_tick = 1'b1; step();
    check("drop_blank", {28'h0, an}, 32'hF);
    scan_tick = 1'b0; step();
    scan_tick = 1'b1; step();
    scan_tick = 1'b0; step();
    check("drop_still_blank", {28'h0, an}, 32'hF);
    step();
    check("drop_an", {28'h0, an}, 32'hD);
    check("drop_cur", {30'h0, cur_digit}, 1);

    // en falls mid-drive on digit 2 together with a tick.
    tick_and_wait();
    check("en_pre_an", {28'h0, an}, 32'hB);
    en = 1'b0; scan_tick = 1'b1; step();
    check("en_off_an", {28'h0, an}, 32'hF);
    check("en_off_cur", {30'h0, cur_digit}, 2);
    step(); step();
    check("en_off_hold", {30'h0, cur_digit}, 2);
    scan_tick = 1'b0; en = 1'b1; step();
    tick_and_wait();
    check("en_resume_an", {28'h0, an}, 32'hB);
    check("en_resume_cur", {30'h0, cur_digit}, 2);

    // Blink on digit 0.
    do_reset();
    blink_mask = 4'b0001;
    tick_and_wait();
    check("blink_on_an", {28'h0, an}, 32'hE);
    blink_clk = 1'b1; step();
    check("blink_off_an", {28'h0, an}, 32'hF);
    check("blink_off_seg", {25'h0, seg}, 32'h7F);
    blink_clk = 1'b0; step();
    check("blink_back_an", {28'h0, an}, 32'hE);
    tick_and_wait();
    blink_clk = 1'b1; step();
    check("blink_other_an", {28'h0, an}, 32'hD);
    blink_clk = 1'b0;

    // Randomized traffic checked every cycle by the model.
    half = 6; hcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 19) != 0);
      if (++hcnt >= half) begin
        hcnt = 0; scan_tick = ~scan_tick; half = $urandom_range(2, 12);
      end
      if ($urandom_range(0, 7) == 0) blink_clk = ~blink_clk;
      if ($urandom_range(0, 9) == 0) digits = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) begin
        blink_mask = 4'($urandom); dp_mask = 4'($urandom); lz_en = 1'($urandom);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
